// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer with run/step/halt debug control.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_start              pulse: PC<=RESET_PC, clear cycle counter, enter RUN
//   i_step               pulse in HALT: perform exactly one fetch
//   i_pcSrc              00 seq, 01 PC+Imm, 10 rs1+Imm, 11 treated as seq
//   i_flush              redirect flush request from EX
//   i_pcImm_target       PC+Imm branch/jal target
//   i_jalr_target        rs1+Imm jalr target (bit 0 is forced to zero)
//   i_stall              load-use stall: hold PC and IF/ID, bubble ID/EX
//   i_halt_instr         HALT opcode present in ID
//   o_pc                 registered fetch PC
//   o_fetch_en           IF stage / IF-ID write enable
//   o_flush_ifid         clear IF/ID this cycle
//   o_flush_idex         clear ID/EX this cycle
//   o_halted             sequencer is in HALT
//   o_done               one-cycle pulse on the last DRAIN cycle
//   o_misaligned         (PC_MISALIGN_TRAP_EN only) sticky misaligned-target flag
//   o_cycle_cnt          saturating count of cycles spent in RUN or DRAIN
module pc_sequencer #(
    parameter int                 NB_DATA    = 32,
    parameter logic [NB_DATA-1:0] RESET_PC   = '0,
    parameter int                 PIPE_DEPTH = 4,
    parameter int                 NB_CNT     = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_step,
    input  logic [1:0]         i_pcSrc,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_pcImm_target,
    input  logic [NB_DATA-1:0] i_jalr_target,
    input  logic               i_stall,
    input  logic               i_halt_instr,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_fetch_en,
    output logic               o_flush_ifid,
    output logic               o_flush_idex,
    output logic               o_halted,
    output logic               o_done,
`ifdef PC_MISALIGN_TRAP_EN
    output logic               o_misaligned,
`endif
    output logic [NB_CNT-1:0]  o_cycle_cnt
);

    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_DEPTH - 1);
    localparam logic [NB_DATA-1:0] JALR_MASK = {{(NB_DATA-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DW-1:0]      drain_q;
    logic [NB_DATA-1:0] pc_d;
    logic [NB_DATA-1:0] pc_inc;
    logic [NB_DATA-1:0] target;
    logic               redir;
    logic               bad_target;
    logic               drain_last;

    // pcSrc=11 is not a redirect and falls through to sequential fetch.
    assign redir  = (i_pcSrc == 2'b01) || (i_pcSrc == 2'b10);
    assign target = (i_pcSrc == 2'b01) ? i_pcImm_target
                                       : (i_jalr_target & JALR_MASK);
    assign pc_inc = o_pc + NB_DATA'(4);
    assign drain_last = (state_q == ST_DRAIN) && (drain_q == '0);

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_set;

    // A taken target that is not word aligned is refused and stops the core.
    assign bad_target = redir && target[1];
    assign trap_set   = bad_target &&
                        ((state_q == ST_RUN) ||
                         ((state_q == ST_HALT) && i_step));
`else
    assign bad_target = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // A HALT seen together with a redirect is on the wrong
                    // path and is dropped; a stalled HALT waits in RUN.
                    if (redir) begin
                        if (bad_target) begin
                            state_d = ST_DRAIN;
                        end
                    end else if (!i_stall && i_halt_instr) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Output and next-PC logic
    always_comb begin
        o_fetch_en   = 1'b0;
        o_flush_ifid = 1'b0;
        o_flush_idex = 1'b0;
        o_done       = 1'b0;
        o_halted     = (state_q == ST_HALT);
        pc_d         = o_pc;
        case (state_q)
            ST_HALT: begin
                if (i_step && !i_start) begin
                    if (redir) begin
                        o_fetch_en   = !bad_target;
                        o_flush_ifid = i_flush;
                        o_flush_idex = i_flush;
                        if (!bad_target) begin
                            pc_d = target;
                        end
                    end else begin
                        o_fetch_en = 1'b1;
                        pc_d       = pc_inc;
                    end
                end
            end
            ST_RUN: begin
                if (redir) begin
                    // Redirect outranks the stall.
                    o_fetch_en   = !bad_target;
                    o_flush_ifid = i_flush;
                    o_flush_idex = i_flush;
                    if (!bad_target) begin
                        pc_d = target;
                    end
                end else if (i_stall) begin
                    o_flush_idex = 1'b1;
                end else if (i_halt_instr) begin
                    // Drop whatever was fetched behind the HALT.
                    o_flush_ifid = 1'b1;
                end else begin
                    o_fetch_en = 1'b1;
                    pc_d       = pc_inc;
                end
            end
            ST_DRAIN: begin
                o_done = drain_last && !i_start;
            end
            default: begin
                o_halted = 1'b0;
            end
        endcase
    end

    // PC, cycle counter, drain counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pc        <= RESET_PC;
            o_cycle_cnt <= '0;
            drain_q     <= '0;
        end else if (i_start) begin
            o_pc        <= RESET_PC;
            o_cycle_cnt <= '0;
            drain_q     <= '0;
        end else begin
            o_pc <= pc_d;
            if ((state_q != ST_HALT) && (o_cycle_cnt != '1)) begin
                o_cycle_cnt <= o_cycle_cnt + NB_CNT'(1);
            end
            if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN)) begin
                drain_q <= DRAIN_INIT;
            end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
                drain_q <= drain_q - DW'(1);
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_misaligned <= 1'b0;
        end else if (i_start) begin
            o_misaligned <= 1'b0;
        end else if (trap_set) begin
            o_misaligned <= 1'b1;
        end
    end
`endif

endmodule
